main_control_fsm: RTL and testbench

//  Multicycle main control unit; sits directly upstream of ALU_control and produces ctrl_ALU_op for it.

---
 rtl/main_control_if.sv | 39 +++
 rtl/main_control_fsm.sv | 173 +++++++++++++++++
 tb/tb_main_control_fsm.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/main_control_if.sv
// Control bundle between the multicycle main control FSM and the datapath/memory.
// Latency: none, wires only.
// Backpressure: memory stalls the FSM through mem_ready; the control outputs have no backpressure.
interface main_control_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic [1:0] ctrl_ALU_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_source;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       reg_write;
  logic       mem_to_reg;
  logic       instr_done;
  logic       illegal_instr;
  logic       mem_err;
  logic [3:0] state_o;

  // Control FSM side: decodes the opcode and drives the datapath enables.
  modport master (
    input  opcode, mem_ready,
    output ctrl_ALU_op, alu_src_a, alu_src_b, pc_source, mem_read, mem_write,
           i_or_d, ir_write, pc_write, pc_write_cond, reg_write, mem_to_reg,
           instr_done, illegal_instr, mem_err, state_o
  );

  // Datapath/memory side.
  modport slave (
    output opcode, mem_ready,
    input  ctrl_ALU_op, alu_src_a, alu_src_b, pc_source, mem_read, mem_write,
           i_or_d, ir_write, pc_write, pc_write_cond, reg_write, mem_to_reg,
           instr_done, illegal_instr, mem_err, state_o
  );
endinterface

// File: rtl/main_control_fsm.sv
// Multicycle main control: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath enables.
// Latency with memory ready on first request cycle: LD 5, SD 4, R 4, BEQ 3 cycles.
// Backpressure: waits in FETCH/MEM_RD/MEM_WR for mem_ready, aborting to FETCH after MEM_TIMEOUT cycles.
module main_control_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  main_control_if.master bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          wait_state;
  logic          timeout;

  // Only the three memory-request states count wait cycles; mem_ready in the same cycle beats the timeout.
  assign wait_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timeout    = wait_state && !bus.mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));

  // State register; reset forces FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Wait counter: counts consecutive not-ready cycles, zero whenever a wait state is (re)entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (wait_state && !bus.mem_ready && !timeout) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Next state and Moore outputs; write strobes additionally qualified by mem_ready, everything 0 in reset.
  always_comb begin
    state_nxt         = state;
    bus.ctrl_ALU_op   = 2'b00;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.reg_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.instr_done    = 1'b0;
    bus.illegal_instr = 1'b0;
    bus.mem_err       = 1'b0;
    bus.state_o       = state;
    if (rst_n) begin
      case (state)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_nxt    = DECODE;
          end else if (timeout) begin
            // Retry the same PC: no PC update happened.
            bus.mem_err = 1'b1;
            state_nxt   = FETCH;
          end
        end
        DECODE: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          case (bus.opcode)
            OP_LD, OP_SD: state_nxt = MEM_ADDR;
            OP_R:         state_nxt = EXEC_R;
            OP_BEQ:       state_nxt = BRANCH;
            default: begin
              bus.illegal_instr = 1'b1;
              state_nxt         = FETCH;
            end
          endcase
        end
        MEM_ADDR: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b10;
          if (bus.opcode == OP_LD) begin
            state_nxt = MEM_RD;
          end else if (bus.opcode == OP_SD) begin
            state_nxt = MEM_WR;
          end else begin
            state_nxt = FETCH;
          end
        end
        MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
          if (bus.mem_ready) begin
            state_nxt = MEM_WB;
          end else if (timeout) begin
            bus.mem_err = 1'b1;
            state_nxt   = FETCH;
          end
        end
        MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
          state_nxt      = FETCH;
        end
        MEM_WR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          if (bus.mem_ready) begin
            bus.instr_done = 1'b1;
            state_nxt      = FETCH;
          end else if (timeout) begin
            bus.mem_err = 1'b1;
            state_nxt   = FETCH;
          end
        end
        EXEC_R: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_src_b   = 2'b00;
          bus.ctrl_ALU_op = 2'b10;
          state_nxt       = ALU_WB;
        end
        ALU_WB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
          state_nxt      = FETCH;
        end
        BRANCH: begin
          bus.alu_src_a     = 2'b10;
          bus.alu_src_b     = 2'b00;
          bus.ctrl_ALU_op   = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 1'b1;
          bus.instr_done    = 1'b1;
          state_nxt         = FETCH;
        end
        default: begin
          state_nxt = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: expands each instruction into its expected per-cycle control trace.
// Latency: one check per clock cycle, sampled 3 time units after the rising edge.
// Backpressure: mem_ready is scripted per cycle by the trace, including timeouts.
module tb_main_control_fsm;

  localparam int TO = 16;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MADDR = 2, S_MRD = 3, S_MWB = 4;
  localparam int S_MWR = 5, S_EXEC = 6, S_AWB = 7, S_BR = 8;

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;
  localparam logic [6:0] OP_ZERO = 7'b0000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  main_control_if bus ();

  main_control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // One expected cycle: inputs to drive plus every output the DUT must show.
  typedef struct packed {
    logic [6:0] opc;
    logic       rdy;
    logic [3:0] st;
    logic [1:0] aluop;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       pcs, mrd, mwr, iord, irw, pcw, pcwc, rw, m2r, done, ill, err;
  } cyc_t;

  cyc_t q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   done_seen  = 0;
  int   err_seen   = 0;

  function automatic cyc_t step(int st, logic [6:0] opc, logic rdy);
    cyc_t c;
    c     = '0;
    c.st  = 4'(st);
    c.opc = opc;
    c.rdy = rdy;
    return c;
  endfunction

  // Instruction fetch: every TO not-ready cycles cost a mem_err and a retry.
  task automatic emit_fetch(logic [6:0] opc, int waits);
    int   w;
    cyc_t c;
    w = waits;
    while (w >= TO) begin
      for (int i = 0; i < TO; i++) begin
        c = step(S_FETCH, opc, 1'b0); c.mrd = 1'b1; c.sb = 2'b01; c.err = (i == TO - 1);
        q.push_back(c);
      end
      w -= TO;
    end
    for (int i = 0; i < w; i++) begin
      c = step(S_FETCH, opc, 1'b0); c.mrd = 1'b1; c.sb = 2'b01;
      q.push_back(c);
    end
    c = step(S_FETCH, opc, 1'b1); c.mrd = 1'b1; c.sb = 2'b01; c.irw = 1'b1; c.pcw = 1'b1;
    q.push_back(c);
  endtask

  // Data access: waits >= TO aborts the instruction with mem_err on the TO-th cycle.
  task automatic emit_mem(int st, logic [6:0] opc, int waits, output bit ok);
    cyc_t c;
    int   n;
    n = (waits >= TO) ? TO : waits;
    for (int i = 0; i < n; i++) begin
      c = step(st, opc, 1'b0); c.iord = 1'b1; c.mrd = (st == S_MRD); c.mwr = (st == S_MWR);
      c.err = (i == TO - 1);
      q.push_back(c);
    end
    ok = (waits < TO);
    if (ok) begin
      c = step(st, opc, 1'b1); c.iord = 1'b1; c.mrd = (st == S_MRD); c.mwr = (st == S_MWR);
      c.done = (st == S_MWR);
      q.push_back(c);
    end
  endtask

  // Whole instruction; mem_ready is driven high in non-memory cycles, where it must be ignored.
  task automatic emit_instr(logic [6:0] opc, int fw, int mw);
    cyc_t c;
    bit   ok;
    emit_fetch(opc, fw);
    c = step(S_DECODE, opc, 1'b1); c.sa = 2'b01; c.sb = 2'b10;
    if (opc != OP_LD && opc != OP_SD && opc != OP_R && opc != OP_BEQ) begin
      c.ill = 1'b1;
      q.push_back(c);
      return;
    end
    q.push_back(c);
    if (opc == OP_LD || opc == OP_SD) begin
      c = step(S_MADDR, opc, 1'b1); c.sa = 2'b10; c.sb = 2'b10;
      q.push_back(c);
      emit_mem((opc == OP_LD) ? S_MRD : S_MWR, opc, mw, ok);
      if (ok && opc == OP_LD) begin
        c = step(S_MWB, opc, 1'b1); c.rw = 1'b1; c.m2r = 1'b1; c.done = 1'b1;
        q.push_back(c);
      end
    end else if (opc == OP_R) begin
      c = step(S_EXEC, opc, 1'b1); c.sa = 2'b10; c.aluop = 2'b10;
      q.push_back(c);
      c = step(S_AWB, opc, 1'b1); c.rw = 1'b1; c.done = 1'b1;
      q.push_back(c);
    end else begin
      c = step(S_BR, opc, 1'b1); c.sa = 2'b10; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcs = 1'b1;
      c.done = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic check_val(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_cycle(cyc_t e, string name);
    logic [21:0] act;
    logic [21:0] exp;
    act = {bus.state_o, bus.ctrl_ALU_op, bus.alu_src_a, bus.alu_src_b, bus.pc_source,
           bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
           bus.pc_write_cond, bus.reg_write, bus.mem_to_reg, bus.instr_done,
           bus.illegal_instr, bus.mem_err};
    exp = {e.st, e.aluop, e.sa, e.sb, e.pcs, e.mrd, e.mwr, e.iord, e.irw, e.pcw, e.pcwc,
           e.rw, e.m2r, e.done, e.ill, e.err};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (state %0d vs %0d)", name, act, exp,
               bus.state_o, e.st);
    end
    if (bus.instr_done === 1'b1) done_seen++;
    if (bus.mem_err === 1'b1) err_seen++;
  endtask

  // Called just after a rising edge: drive, check 2 units later, advance one cycle.
  task automatic run_queue(string tag);
    cyc_t e;
    int   n;
    n = 0;
    while (q.size() > 0) begin
      e             = q.pop_front();
      bus.opcode    = e.opc;
      bus.mem_ready = e.rdy;
      #2;
      check_cycle(e, $sformatf("%s_cyc%0d", tag, n));
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    cyc_t z;
    bus.opcode    = OP_ZERO;
    bus.mem_ready = 1'b0;
    z             = '0;

    // Everything low in reset, even with memory signalling ready.
    #12;
    check_cycle(z, "reset_outputs");
    bus.mem_ready = 1'b1;
    #1;
    check_cycle(z, "reset_outputs_rdy");
    bus.mem_ready = 1'b0;

    // Pin the trace model with hand-computed lengths and timeout position.
    emit_instr(OP_R, 0, 0);    check_val("model_len_R", q.size(), 4);    q.delete();
    emit_instr(OP_LD, 0, 3);   check_val("model_len_LD_wait3", q.size(), 8); q.delete();
    emit_instr(OP_SD, 0, 0);   check_val("model_len_SD", q.size(), 4);   q.delete();
    emit_instr(OP_BEQ, 0, 0);  check_val("model_len_BEQ", q.size(), 3);  q.delete();
    emit_instr(OP_R, 16, 0);
    check_val("model_len_R_fetch_timeout", q.size(), 20);
    check_val("model_err_cycle16", int'(q[15].err), 1);
    check_val("model_no_irw_before_retry", int'(q[15].irw), 0);
    q.delete();

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    emit_instr(OP_R,    0,  0);
    emit_instr(OP_LD,   0,  3);
    emit_instr(OP_BEQ,  0,  0);
    emit_instr(OP_BAD,  0,  0);
    emit_instr(OP_R,    16, 0);
    emit_instr(OP_SD,   15, 2);
    emit_instr(OP_LD,   0,  20);
    emit_instr(OP_SD,   0,  0);
    emit_instr(OP_ZERO, 0,  0);
    run_queue("main");
    check_val("instr_done_pulses", done_seen, 6);
    check_val("mem_err_pulses", err_seen, 2);

    // Reset pulse while a store waits in MEM_WR.
    emit_instr(OP_SD, 0, TO + 5);
    while (q.size() > 5) void'(q.pop_back());
    run_queue("sd_pre");
    bus.opcode    = OP_SD;
    bus.mem_ready = 1'b0;
    #1;
    check_val("mem_write_before_rst", int'(bus.mem_write), 1);
    check_val("state_before_rst", int'(bus.state_o), S_MWR);
    rst_n = 1'b0;
    #1;
    check_val("mem_write_in_rst", int'(bus.mem_write), 0);
    check_val("mem_read_in_rst", int'(bus.mem_read), 0);
    rst_n = 1'b1;
    #1;
    check_val("state_after_rst", int'(bus.state_o), S_FETCH);
    check_val("mem_read_after_rst", int'(bus.mem_read), 1);
    emit_instr(OP_R, 0, 0);
    run_queue("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
